// File: rtl/mux_and_gate.sv
// Bitwise AND of two equal-width operands built from per-bit 2:1 mux cells,
// with an optional output register (synchronous active-high reset).

module mux_and_gate_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic o
);

    // Unselected leg is never looked at, so sel=0 masks an unknown d1.
    assign o = sel ? d1 : d0;

endmodule

module mux_and_gate #(
    parameter int unsigned WIDTH           = 1,
    parameter bit          REGISTER_OUTPUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] m;

    // One mux per bit: a selects between constant 0 and b.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        mux_and_gate_mux2 u_mux (
            .sel (a[i]),
            .d0  (1'b0),
            .d1  (b[i]),
            .o   (m[i])
        );
    end

    if (REGISTER_OUTPUT) begin : g_reg
        logic [WIDTH-1:0] y_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                y_q <= '0;
            end else begin
                y_q <= m;
            end
        end

        assign y = y_q;
    end else begin : g_comb
        // Clock and reset are intentionally unused in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign y = m;
    end

endmodule

// File: tb/tb_mux_and_gate.sv
// Bench for mux_and_gate: registered WIDTH=1 and WIDTH=4 instances driven from a
// shared vector table via a scoreboard, plus a combinational WIDTH=1 instance.

module tb_mux_and_gate;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic       e1;
        logic [3:0] e4;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a   = '0;
    logic [3:0] b   = '0;
    logic [0:0] y1;
    logic [3:0] y4;

    logic       clk_c = 1'b0;
    logic       rst_c = 1'b0;
    logic [0:0] ac    = '0;
    logic [0:0] bc    = '0;
    logic [0:0] yc;

    int checks   = 0;
    int failures = 0;

    logic  q_e1[$];
    logic [3:0] q_e4[$];
    string q_nm[$];

    always #5 clk = ~clk;

    mux_and_gate #(.WIDTH(1), .REGISTER_OUTPUT(1'b1)) u_w1 (
        .clk (clk), .rst (rst), .a (a[0:0]), .b (b[0:0]), .y (y1)
    );

    mux_and_gate #(.WIDTH(4), .REGISTER_OUTPUT(1'b1)) u_w4 (
        .clk (clk), .rst (rst), .a (a), .b (b), .y (y4)
    );

    mux_and_gate #(.WIDTH(1), .REGISTER_OUTPUT(1'b0)) u_comb (
        .clk (clk_c), .rst (rst_c), .a (ac), .b (bc), .y (yc)
    );

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Compare whatever the previous edge produced, then drive the next vector.
    task automatic step(input vec_t v);
        @(negedge clk);
        if (q_e1.size() != 0) begin
            string nm;
            nm = q_nm.pop_front();
            check1({nm, "/w1"}, y1[0], q_e1.pop_front());
            check4({nm, "/w4"}, y4, q_e4.pop_front());
        end
        rst = v.rst;
        a   = v.a;
        b   = v.b;
        q_e1.push_back(v.e1);
        q_e4.push_back(v.e4);
        q_nm.push_back(v.name);
    endtask

    task automatic drain();
        @(negedge clk);
        while (q_e1.size() != 0) begin
            string nm;
            nm = q_nm.pop_front();
            check1({nm, "/w1"}, y1[0], q_e1.pop_front());
            check4({nm, "/w4"}, y4, q_e4.pop_front());
        end
    endtask

    vec_t vecs[$];

    initial begin
        // bit 0 walks the 1-bit truth table; all 4 bits follow the wide vectors
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, "init_rst"});
        vecs.push_back('{1'b0, 4'b1100, 4'b1010, 1'b0, 4'b1000, "ab00"});
        vecs.push_back('{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, "ab01"});
        vecs.push_back('{1'b0, 4'b1111, 4'b0110, 1'b0, 4'b0110, "ab10"});
        vecs.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, "ab11"});
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, "rst_hold0"});
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, "rst_hold1"});
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, "rst_hold2"});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, "rst_release"});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, "stream0"});
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, "mid_rst"});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, "after_rst0"});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, "after_rst1"});
        vecs.push_back('{1'b0, 4'b0000, 4'bxxxx, 1'b0, 4'b0000, "x_mask"});
        vecs.push_back('{1'b0, 4'b0101, 4'b0011, 1'b1, 4'b0001, "mixed"});
        vecs.push_back('{1'b1, 4'b0101, 4'b0011, 1'b0, 4'b0000, "rst_prio"});

        foreach (vecs[i]) step(vecs[i]);

        // Random stream checked against a plain bitwise-AND model.
        for (int i = 0; i < 24; i++) begin
            vec_t v;
            v.rst  = ($urandom_range(0, 7) == 0);
            v.a    = 4'($urandom_range(0, 15));
            v.b    = 4'($urandom_range(0, 15));
            v.e4   = v.rst ? 4'b0000 : (v.a & v.b);
            v.e1   = v.e4[0];
            v.name = "rand";
            step(v);
        end
        drain();

        // Combinational instance: clk idle, result settles within the step.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic       exp;
            ab    = 2'(i);
            ac[0] = ab[1];
            bc[0] = ab[0];
            exp   = (i == 3);
            #1;
            check1("comb", yc[0], exp);
            rst_c = 1'b1;
            clk_c = 1'b1;
            #1;
            check1("comb_rst_ignored", yc[0], exp);
            rst_c = 1'b0;
            clk_c = 1'b0;
            #8;
        end
        ac[0] = 1'b0;
        bc[0] = 1'bx;
        #1;
        check1("comb_x_mask", yc[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
